noise_filter_ctrl: RTL and testbench

- Clocked controller and scheduler for an array of digital noise-filter channels on external pins.
- Synchronizes each raw pin input and gates sampling with a shared programmable prescaler tick.
- A filtered level is accepted only after FLT_LEN consecutive differing samples.
- Programmed edges of the filtered level raise per-channel interrupt-pending flags, cleared by acknowledge.
- Sits between the pad input cells and the interrupt/port logic.

---
 rtl/noise_filter_ctrl.sv | 152 +++++++++++++++
 tb/tb_noise_filter_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/noise_filter_ctrl.sv
// Noise-filter controller: per-channel 2-FF synchronizer, shared prescaler tick,
// stability-count filter and edge interrupt flags. Optional BYPASS port under NFC_BYPASS_EN.
module noise_filter_ctrl #(
    parameter int NCH  = 4,
    parameter int PS_W = 8,
    parameter int FL_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [PS_W-1:0]   PRESCALE,
    input  logic [FL_W-1:0]   FLT_LEN,
    input  logic [2*NCH-1:0]  EDGE_SEL,
    input  logic [NCH-1:0]    H_IN,
    input  logic [NCH-1:0]    IRQ_ACK,
`ifdef NFC_BYPASS_EN
    input  logic [NCH-1:0]    BYPASS,
`endif
    output logic [NCH-1:0]    N_OUT,
    output logic [NCH-1:0]    IRQ_PEND,
    output logic              IRQ,
    output logic              TICK
);

    typedef enum logic {
        CH_STABLE = 1'b0,
        CH_COUNT  = 1'b1
    } ch_state_e;

    ch_state_e       state_q [NCH];
    ch_state_e       state_d [NCH];
    logic [FL_W-1:0] cnt_q   [NCH];
    logic [FL_W-1:0] cnt_d   [NCH];

    logic [NCH-1:0]  sync1;
    logic [NCH-1:0]  sync2;
    logic [NCH-1:0]  bypass;
    logic [NCH-1:0]  differ;
    logic [NCH-1:0]  reach;
    logic [NCH-1:0]  nout_d;
    logic [NCH-1:0]  pend_d;
    logic [NCH-1:0]  irq_set;
    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    logic [FL_W:0]   eff_len;

`ifdef NFC_BYPASS_EN
    assign bypass = BYPASS;
`else
    assign bypass = '0;
`endif

    // A programmed length of zero behaves like a length of one.
    assign eff_len = (FLT_LEN == '0) ? (FL_W+1)'(1) : {1'b0, FLT_LEN};
    assign TICK    = tick;
    assign IRQ     = |IRQ_PEND;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= H_IN;
            sync2 <= sync1;
        end
    end

    // The >= compare makes a PRESCALE lowered below the running count wrap at once.
    always_ff @(posedge CLK) begin
        if (RST || !EN) begin
            ps_cnt <= '0;
            tick   <= 1'b0;
        end else if (ps_cnt >= PRESCALE) begin
            ps_cnt <= '0;
            tick   <= 1'b1;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
            tick   <= 1'b0;
        end
    end

    always_comb begin
        differ = '0;
        reach  = '0;
        for (int i = 0; i < NCH; i++) begin
            differ[i] = (sync2[i] != N_OUT[i]);
            reach[i]  = (({1'b0, cnt_q[i]} + (FL_W+1)'(1)) >= eff_len);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            N_OUT    <= '0;
            IRQ_PEND <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= CH_STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            N_OUT    <= nout_d;
            IRQ_PEND <= pend_d;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            if (bypass[i] || !EN) begin
                state_d[i] = CH_STABLE;
            end else if (tick) begin
                case (state_q[i])
                    CH_STABLE: if (differ[i] && !reach[i]) state_d[i] = CH_COUNT;
                    CH_COUNT:  if (!differ[i] || reach[i]) state_d[i] = CH_STABLE;
                    default:   state_d[i] = CH_STABLE;
                endcase
            end
        end
    end

    // In STABLE the count is zero, so one shared rule covers both states.
    always_comb begin
        nout_d  = N_OUT;
        pend_d  = IRQ_PEND;
        irq_set = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (bypass[i]) begin
                cnt_d[i]  = '0;
                nout_d[i] = sync1[i];
            end else if (!EN) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (!differ[i]) begin
                    cnt_d[i] = '0;
                end else if (reach[i]) begin
                    cnt_d[i]  = '0;
                    nout_d[i] = sync2[i];
                end else if (cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + FL_W'(1);
                end
            end
            irq_set[i] = (nout_d[i] & ~N_OUT[i] & EDGE_SEL[2*i]) |
                         (~nout_d[i] & N_OUT[i] & EDGE_SEL[2*i+1]);
            pend_d[i]  = irq_set[i] | (IRQ_PEND[i] & ~IRQ_ACK[i]);
        end
    end

endmodule

// File: tb/tb_noise_filter_ctrl.sv
// Directed bench for noise_filter_ctrl; expected values are hand-derived cycle counts.
// Exercises the BYPASS port as well when NFC_BYPASS_EN is defined.
module tb_noise_filter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] prescale;
    logic [3:0] flt_len;
    logic [7:0] edge_sel;
    logic [3:0] h_in;
    logic [3:0] irq_ack;
    logic [3:0] bypass;
    logic [3:0] n_out;
    logic [3:0] irq_pend;
    logic       irq;
    logic       tick;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    noise_filter_ctrl #(.NCH(4), .PS_W(8), .FL_W(4)) dut (
        .CLK      (clk),
        .RST      (rst),
        .EN       (en),
        .PRESCALE (prescale),
        .FLT_LEN  (flt_len),
        .EDGE_SEL (edge_sel),
        .H_IN     (h_in),
        .IRQ_ACK  (irq_ack),
`ifdef NFC_BYPASS_EN
        .BYPASS   (bypass),
`endif
        .N_OUT    (n_out),
        .IRQ_PEND (irq_pend),
        .IRQ      (irq),
        .TICK     (tick)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] h, input logic [3:0] ack);
        h_in    = h;
        irq_ack = ack;
    endtask

    initial begin
        int seen;
        rst = 1'b1; en = 1'b0; prescale = 8'd0; flt_len = 4'd3;
        edge_sel = 8'h00; bypass = 4'h0;
        applyStimulus(4'h0, 4'h0);
        waitCycles(2);
        checkOutput("reset_nout", 32'(n_out), 32'h0);
        checkOutput("reset_pend", 32'(irq_pend), 32'h0);
        checkOutput("reset_tick", 32'(tick), 32'h0);
        checkOutput("reset_irq", 32'(irq), 32'h0);

        // Five-cycle latency with PRESCALE=0, FLT_LEN=3.
        rst = 1'b0; en = 1'b1;
        waitCycles(3);
        applyStimulus(4'h1, 4'h0);
        waitCycles(4);
        checkOutput("lat_before", 32'(n_out), 32'h0);
        waitCycles(1);
        checkOutput("lat_at5", 32'(n_out), 32'h1);

        applyStimulus(4'h0, 4'h0);
        waitCycles(8);
        checkOutput("back_low", 32'(n_out), 32'h0);
        applyStimulus(4'h1, 4'h0);
        waitCycles(2);
        applyStimulus(4'h0, 4'h0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            waitCycles(1);
            seen = seen | int'(n_out) | int'(irq_pend);
        end
        checkOutput("glitch_reject", 32'(seen), 32'h0);

        // PRESCALE=3: tick every 4 cycles, two ticks to qualify.
        rst = 1'b1; prescale = 8'd3; flt_len = 4'd2;
        waitCycles(1);
        rst = 1'b0;
        waitCycles(3);
        checkOutput("tick_a3", 32'(tick), 32'h0);
        waitCycles(1);
        checkOutput("tick_a4", 32'(tick), 32'h1);
        waitCycles(1);
        checkOutput("tick_a5", 32'(tick), 32'h0);
        waitCycles(3);
        checkOutput("tick_a8", 32'(tick), 32'h1);
        applyStimulus(4'h1, 4'h0);
        waitCycles(8);
        checkOutput("ps_before", 32'(n_out), 32'h0);
        waitCycles(1);
        checkOutput("ps_update", 32'(n_out), 32'h1);
        applyStimulus(4'h0, 4'h0);
        waitCycles(4);
        en = 1'b0;
        waitCycles(10);
        checkOutput("en_off_hold", 32'(n_out), 32'h1);
        checkOutput("en_off_tick", 32'(tick), 32'h0);
        en = 1'b1;
        waitCycles(8);
        checkOutput("en_fresh_before", 32'(n_out), 32'h1);
        waitCycles(1);
        checkOutput("en_fresh_update", 32'(n_out), 32'h0);

        // Falling-edge-only IRQ on channel 0.
        prescale = 8'd0; edge_sel = 8'h02;
        applyStimulus(4'h1, 4'h0);
        waitCycles(8);
        checkOutput("rise_nout", 32'(n_out), 32'h1);
        checkOutput("rise_no_irq", 32'(irq_pend), 32'h0);
        applyStimulus(4'h0, 4'h0);
        waitCycles(8);
        checkOutput("fall_nout", 32'(n_out), 32'h0);
        checkOutput("fall_pend", 32'(irq_pend), 32'h1);
        checkOutput("fall_irq", 32'(irq), 32'h1);
        applyStimulus(4'h1, 4'h0);
        waitCycles(8);
        checkOutput("rise2_pend", 32'(irq_pend), 32'h1);
        applyStimulus(4'h0, 4'h0);
        waitCycles(3);
        checkOutput("coinc_pre", 32'(n_out), 32'h1);
        applyStimulus(4'h0, 4'h1);
        waitCycles(1);
        applyStimulus(4'h0, 4'h0);
        checkOutput("coinc_nout", 32'(n_out), 32'h0);
        checkOutput("coinc_set_wins", 32'(irq_pend), 32'h1);
        applyStimulus(4'h0, 4'h1);
        waitCycles(1);
        applyStimulus(4'h0, 4'h0);
        checkOutput("ack_clear", 32'(irq_pend), 32'h0);
        checkOutput("ack_irq", 32'(irq), 32'h0);
        edge_sel = 8'h40;
        applyStimulus(4'h8, 4'h0);
        waitCycles(8);
        checkOutput("ch3_nout", 32'(n_out), 32'h8);
        checkOutput("ch3_pend", 32'(irq_pend), 32'h8);

        // Reset mid-count on channel 2, then a full 4-tick requalification.
        flt_len = 4'd4; edge_sel = 8'h00;
        applyStimulus(4'h4, 4'h0);
        waitCycles(4);
        checkOutput("mid_count", 32'(n_out[2]), 32'h0);
        rst = 1'b1;
        waitCycles(1);
        checkOutput("rst_nout", 32'(n_out), 32'h0);
        checkOutput("rst_pend", 32'(irq_pend), 32'h0);
        checkOutput("rst_tick", 32'(tick), 32'h0);
        checkOutput("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        waitCycles(5);
        checkOutput("requal_before", 32'(n_out), 32'h0);
        waitCycles(1);
        checkOutput("requal_done", 32'(n_out), 32'h4);

`ifdef NFC_BYPASS_EN
        bypass = 4'h2; prescale = 8'd7; edge_sel = 8'h04;
        applyStimulus(4'h6, 4'h0);
        waitCycles(1);
        applyStimulus(4'h4, 4'h0);
        checkOutput("byp_g1", 32'(n_out[1]), 32'h0);
        waitCycles(1);
        checkOutput("byp_g2", 32'(n_out[1]), 32'h1);
        checkOutput("byp_pend", 32'(irq_pend[1]), 32'h1);
        waitCycles(1);
        checkOutput("byp_g3", 32'(n_out[1]), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
